// File: rtl/e_branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
interface e_branch_predictor_if #(
  parameter int PC_W  = 13,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  f_pc;
  logic [PC_W-1:0]  pc_predicted;
  logic             pred_taken;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [PC_W-1:0]  upd_target;
  logic             upd_taken;
  logic             upd_is_jump;
  logic             upd_mispredict;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output f_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
    input  pc_predicted, pred_taken, mispredict_cnt
  );

  modport slave (
    input  f_pc, upd_valid, upd_pc, upd_target, upd_taken, upd_is_jump, upd_mispredict,
    output pc_predicted, pred_taken, mispredict_cnt
  );
endinterface

// File: rtl/e_branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, trained by the
// execute stage, plus a saturating mispredict counter for performance debug.
module e_branch_predictor #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 13,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  e_branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic             r_valid  [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [PC_W-1:0]  r_target [DEPTH];
  logic [1:0]       r_ctr    [DEPTH];
  logic [CNT_W-1:0] r_mis_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_pred_taken;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [1:0]       w_upd_ctr;

  assign w_idx     = bp.f_pc[IDX_W-1:0];
  assign w_tag     = bp.f_pc[PC_W-1:IDX_W];
  assign w_upd_idx = bp.upd_pc[IDX_W-1:0];
  assign w_upd_tag = bp.upd_pc[PC_W-1:IDX_W];

  // Zero-latency lookup; reads pre-update table contents (no write bypass).
  always_comb begin
    w_hit           = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_pred_taken    = w_hit && r_ctr[w_idx][1];
    bp.pred_taken   = w_pred_taken;
    bp.pc_predicted = w_pred_taken ? r_target[w_idx] : bp.f_pc + PC_W'(1);
  end

  // Next counter value for the entry being trained.
  always_comb begin
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_upd_ctr = r_ctr[w_upd_idx];
    if (bp.upd_taken) begin
      if (bp.upd_is_jump)                   w_upd_ctr = 2'b11;
      else if (!w_upd_hit)                  w_upd_ctr = 2'b10;
      else if (r_ctr[w_upd_idx] != 2'b11)   w_upd_ctr = r_ctr[w_upd_idx] + 2'd1;
    end else if (w_upd_hit && r_ctr[w_upd_idx] != 2'b00) begin
      w_upd_ctr = r_ctr[w_upd_idx] - 2'd1;
    end
  end

  // Valid bits and counters: cleared to invalid / weakly-not-taken on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (bp.upd_valid) begin
      if (bp.upd_taken) r_valid[w_upd_idx] <= 1'b1;
      // Not-taken misses leave the entry alone; w_upd_ctr holds its old value.
      if (bp.upd_taken || w_upd_hit) r_ctr[w_upd_idx] <= w_upd_ctr;
    end
  end

  // Tag/target only written by taken updates; no reset needed since valid gates them.
  always_ff @(posedge clk) begin
    if (!rst && bp.upd_valid && bp.upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= bp.upd_target;
    end
  end

  // Saturating mispredict statistics counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis_cnt <= '0;
    end else if (bp.upd_valid && bp.upd_mispredict && r_mis_cnt != '1) begin
      r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign bp.mispredict_cnt = r_mis_cnt;
endmodule

// File: tb/tb_e_branch_predictor.sv
module tb_e_branch_predictor;
  localparam int PC_W = 13;

  typedef struct {
    string           name;
    logic            taken;
    logic [PC_W-1:0] pc;
    logic [15:0]     cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [3:0] sb_small[$];
  logic [15:0] exp_cnt;

  e_branch_predictor_if #(.PC_W(PC_W), .CNT_W(16)) bp_if ();
  e_branch_predictor_if #(.PC_W(PC_W), .CNT_W(4))  sm_if ();

  e_branch_predictor #(.IDX_W(4), .PC_W(PC_W), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  e_branch_predictor #(.IDX_W(4), .PC_W(PC_W), .CNT_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bp  (sm_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Push expectation for f_pc, let combinational logic settle, pop and compare.
  task automatic lookup(input string name, input logic [PC_W-1:0] pc,
                        input logic exp_taken, input logic [PC_W-1:0] exp_pc);
    exp_t e;
    bp_if.f_pc = pc;
    sb.push_back('{name: name, taken: exp_taken, pc: exp_pc, cnt: exp_cnt});
    #1;
    e = sb.pop_front();
    checks++;
    if (bp_if.pred_taken !== e.taken) begin
      errors++;
      $display("FAIL %s pred_taken: got %b expected %b", e.name, bp_if.pred_taken, e.taken);
    end
    checks++;
    if (bp_if.pc_predicted !== e.pc) begin
      errors++;
      $display("FAIL %s pc_predicted: got %h expected %h", e.name, bp_if.pc_predicted, e.pc);
    end
    checks++;
    if (bp_if.mispredict_cnt !== e.cnt) begin
      errors++;
      $display("FAIL %s mispredict_cnt: got %0d expected %0d", e.name, bp_if.mispredict_cnt, e.cnt);
    end
  endtask

  // Drive one update for one clock edge; model the statistics counter.
  task automatic update(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                        input logic taken, input logic jump, input logic mis);
    bp_if.upd_valid      = 1'b1;
    bp_if.upd_pc         = pc;
    bp_if.upd_target     = tgt;
    bp_if.upd_taken      = taken;
    bp_if.upd_is_jump    = jump;
    bp_if.upd_mispredict = mis;
    @(posedge clk);
    if (rst) exp_cnt = '0;
    else if (mis && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    #1;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_cnt = '0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup("reset_0010", 13'h0010, 1'b0, 13'h0011);
    lookup("reset_wrap", 13'h1FFF, 1'b0, 13'h0000);
  endtask

  task automatic test_allocate();
    update(13'h0023, 13'h0100, 1'b1, 1'b0, 1'b0);
    lookup("alloc_hit", 13'h0023, 1'b1, 13'h0100);
    lookup("alloc_alias", 13'h0033, 1'b0, 13'h0034);
  endtask

  task automatic test_counter();
    update(13'h0023, 13'h0100, 1'b0, 1'b0, 1'b0);   // 10 -> 01
    lookup("ctr_nt1", 13'h0023, 1'b0, 13'h0024);
    update(13'h0023, 13'h0100, 1'b0, 1'b0, 1'b0);   // 01 -> 00
    lookup("ctr_nt2", 13'h0023, 1'b0, 13'h0024);
    update(13'h0053, 13'h0777, 1'b0, 1'b0, 1'b0);   // not-taken miss: no change
    update(13'h0023, 13'h0100, 1'b1, 1'b0, 1'b0);   // 00 -> 01 (still valid, not realloc)
    lookup("ctr_still_valid", 13'h0023, 1'b0, 13'h0024);
    update(13'h0023, 13'h0100, 1'b1, 1'b0, 1'b0);   // 01 -> 10
    update(13'h0023, 13'h0120, 1'b1, 1'b0, 1'b0);   // 10 -> 11, new target
    lookup("ctr_sat_target", 13'h0023, 1'b1, 13'h0120);
    update(13'h0023, 13'h0120, 1'b1, 1'b0, 1'b0);   // stays 11
    update(13'h0023, 13'h0555, 1'b0, 1'b0, 1'b0);   // 11 -> 10, target unchanged
    lookup("ctr_after_nt", 13'h0023, 1'b1, 13'h0120);
  endtask

  task automatic test_jump();
    update(13'h0045, 13'h0007, 1'b1, 1'b1, 1'b0);
    lookup("jump_hit", 13'h0045, 1'b1, 13'h0007);
    // Read-during-write: same-cycle lookup sees old target.
    bp_if.upd_valid   = 1'b1;
    bp_if.upd_pc      = 13'h0045;
    bp_if.upd_target  = 13'h0009;
    bp_if.upd_taken   = 1'b1;
    bp_if.upd_is_jump = 1'b1;
    lookup("rdw_old", 13'h0045, 1'b1, 13'h0007);
    @(posedge clk);
    #1;
    bp_if.upd_valid = 1'b0;
    lookup("rdw_new", 13'h0045, 1'b1, 13'h0009);
    update(13'h0055, 13'h0200, 1'b1, 1'b1, 1'b0);   // evicts 0x0045
    lookup("jump_evict_old", 13'h0045, 1'b0, 13'h0046);
    lookup("jump_evict_new", 13'h0055, 1'b1, 13'h0200);
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 3; i++) update(13'h00F0, 13'h0000, 1'b0, 1'b0, 1'b1);
    lookup("mis_three", 13'h0010, 1'b0, 13'h0011);
    bp_if.upd_mispredict = 1'b1;
    @(posedge clk);
    #1;
    bp_if.upd_mispredict = 1'b0;
    lookup("mis_no_valid", 13'h0010, 1'b0, 13'h0011);
    // 4-bit counter instance saturates at 0xF.
    for (int i = 0; i < 16; i++) begin
      sm_if.upd_valid      = 1'b1;
      sm_if.upd_mispredict = 1'b1;
      @(posedge clk);
      #1;
      sb_small.push_back((i >= 14) ? 4'hF : 4'(i + 1));
      checks++;
      if (sm_if.mispredict_cnt !== sb_small[0]) begin
        errors++;
        $display("FAIL small_cnt_%0d: got %h expected %h", i, sm_if.mispredict_cnt, sb_small[0]);
      end
      void'(sb_small.pop_front());
    end
    sm_if.upd_valid      = 1'b0;
    sm_if.upd_mispredict = 1'b0;
  endtask

  task automatic test_reset_priority();
    update(13'h0023, 13'h0100, 1'b1, 1'b1, 1'b0);
    lookup("pre_reset", 13'h0023, 1'b1, 13'h0100);
    rst = 1'b1;
    update(13'h0045, 13'h0300, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    lookup("rst_drop_23", 13'h0023, 1'b0, 13'h0024);
    lookup("rst_drop_45", 13'h0045, 1'b0, 13'h0046);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    rst     = 1'b1;
    bp_if.f_pc = '0;
    bp_if.upd_valid = 1'b0;
    bp_if.upd_pc = '0;
    bp_if.upd_target = '0;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_is_jump = 1'b0;
    bp_if.upd_mispredict = 1'b0;
    sm_if.f_pc = '0;
    sm_if.upd_valid = 1'b0;
    sm_if.upd_pc = 13'h00F0;
    sm_if.upd_target = '0;
    sm_if.upd_taken = 1'b0;
    sm_if.upd_is_jump = 1'b0;
    sm_if.upd_mispredict = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_allocate();
    test_counter();
    test_jump();
    test_mispredict();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
